// File: rtl/i2s_frame_ctrl_pkg.sv
// Shared types and elaboration helpers for the I2S frame controller.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

  // Slot counter width; never below one bit so degenerate slots still elaborate.
  function automatic int cnt_width(input int slot_width);
    return (slot_width > 1) ? $clog2(slot_width) : 1;
  endfunction

  // A slot needs the one-bit I2S delay cycle plus DATA_WIDTH data cycles.
  function automatic bit cfg_ok(input int data_width, input int slot_width);
    return (data_width >= 1) && (slot_width >= data_width + 1);
  endfunction

endpackage

// File: rtl/i2s_frame_ctrl_shifter.sv
// MSB-first shift register: parallel load / serial out and serial in / parallel out.
module i2s_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic             ser_o,
  output logic [WIDTH-1:0] par_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // Load wins over shift; shifting moves toward the MSB and pulls ser_i into bit 0.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = load_data_i;
    end else if (shift_i) begin
      sr_d = WIDTH'({sr_q, ser_i});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_o = sr_q[WIDTH-1];
  assign par_o = sr_q;

endmodule

// File: rtl/i2s_frame_ctrl.sv
// I2S master frame controller: word-select generation, rx deserialization with
// left/right strobes, and tx serialization of the frame-latched words.
module i2s_frame_ctrl
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SLOT_WIDTH = 16
) (
  input  logic                  sck,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sd_in,
  input  logic [DATA_WIDTH-1:0] tx_ldata,
  input  logic [DATA_WIDTH-1:0] tx_rdata,
  output logic                  ws,
  output logic                  sd_out,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  l_vld,
  output logic                  r_vld,
  output logic                  busy
);

  localparam int                CNT_W    = cnt_width(SLOT_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_DATA = CNT_W'(DATA_WIDTH);

  generate
    if (!cfg_ok(DATA_WIDTH, SLOT_WIDTH)) begin : g_cfg_err
      $error("i2s_frame_ctrl: SLOT_WIDTH must be at least DATA_WIDTH+1");
    end
  endgenerate

  i2s_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_r_q, tx_r_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sd_out_q, sd_out_d;
  logic                  l_vld_q, l_vld_d;
  logic                  r_vld_q, r_vld_d;

  logic                  active, slot_end, frame_start;
  logic                  rx_win, rx_done, tx_win, tx_load;
  logic [DATA_WIDTH-1:0] tx_load_word;
  logic                  tx_msb;
  logic [DATA_WIDTH-1:0] rx_par, rx_word;
  logic [DATA_WIDTH-1:0] unused_tx_par;
  logic                  unused_rx_ser;

  // Frame sequencing: a frame is LEFT then RIGHT; en is only consulted at frame boundaries.
  always_comb begin
    active      = (state_q != IDLE);
    slot_end    = active && (cnt_q == CNT_LAST);
    state_d     = state_q;
    frame_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d     = LEFT;
          frame_start = 1'b1;
        end
      end
      LEFT: begin
        if (slot_end) state_d = RIGHT;
      end
      RIGHT: begin
        if (slot_end) begin
          if (en) begin
            state_d     = LEFT;
            frame_start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!active || slot_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Data bits occupy cnt 1..DATA_WIDTH; the tx bit for cnt k is staged while cnt is k-1.
  always_comb begin
    rx_win       = active && (cnt_q != '0) && (cnt_q <= CNT_DATA);
    rx_done      = active && (cnt_q == CNT_DATA);
    tx_win       = active && (cnt_q < CNT_DATA);
    tx_load      = frame_start || ((state_q == LEFT) && slot_end);
    tx_load_word = frame_start ? tx_ldata : tx_r_q;
    tx_r_d       = frame_start ? tx_rdata : tx_r_q;
    sd_out_d     = tx_win ? tx_msb : 1'b0;
    rx_word      = DATA_WIDTH'({rx_par, sd_in});
    data_d       = rx_done ? rx_word : data_q;
    l_vld_d      = rx_done && (state_q == LEFT);
    r_vld_d      = rx_done && (state_q == RIGHT);
  end

  i2s_shifter #(
    .WIDTH (DATA_WIDTH)
  ) u_tx_shifter (
    .clk         (sck),
    .rst         (rst),
    .load_i      (tx_load),
    .load_data_i (tx_load_word),
    .shift_i     (tx_win),
    .ser_i       (1'b0),
    .ser_o       (tx_msb),
    .par_o       (unused_tx_par)
  );

  i2s_shifter #(
    .WIDTH (DATA_WIDTH)
  ) u_rx_shifter (
    .clk         (sck),
    .rst         (rst),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (rx_win),
    .ser_i       (sd_in),
    .ser_o       (unused_rx_ser),
    .par_o       (rx_par)
  );

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tx_r_q   <= '0;
      data_q   <= '0;
      sd_out_q <= 1'b0;
      l_vld_q  <= 1'b0;
      r_vld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_r_q   <= tx_r_d;
      data_q   <= data_d;
      sd_out_q <= sd_out_d;
      l_vld_q  <= l_vld_d;
      r_vld_q  <= r_vld_d;
    end
  end

  assign ws     = (state_q == RIGHT);
  assign busy   = active;
  assign sd_out = sd_out_q;
  assign data   = data_q;
  assign l_vld  = l_vld_q;
  assign r_vld  = r_vld_q;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Self-checking bench for i2s_frame_ctrl: frame-position reference model checked
// every cycle, table-driven loopback and bit-position vectors, directed corner cases.
module tb_i2s_frame_ctrl;

  localparam int DW = 8;
  localparam int SW = 16;

  logic          sck = 1'b0;
  logic          rst, en, sd_in, sd_drv, loop_mode;
  logic [DW-1:0] tx_ldata, tx_rdata, data;
  logic          ws, sd_out, l_vld, r_vld, busy;

  int vectors     = 0;
  int miscompares = 0;

  assign sd_in = loop_mode ? sd_out : sd_drv;

  always #5 sck = ~sck;

  i2s_frame_ctrl #(
    .DATA_WIDTH (DW),
    .SLOT_WIDTH (SW)
  ) dut (
    .sck      (sck),
    .rst      (rst),
    .en       (en),
    .sd_in    (sd_in),
    .tx_ldata (tx_ldata),
    .tx_rdata (tx_rdata),
    .ws       (ws),
    .sd_out   (sd_out),
    .data     (data),
    .l_vld    (l_vld),
    .r_vld    (r_vld),
    .busy     (busy)
  );

  // Reference model: pos is the sck position inside the frame (0..2*SW-1), -1 when idle.
  int            pos;
  logic [DW-1:0] mw  [2];
  logic [DW-1:0] mrx [2];
  logic [DW-1:0] mdata;
  logic          mlv, mrv;

  logic [DW-1:0] cap_l, cap_r;
  int            n_l, n_r;
  int            cyc, last_rise, period;
  logic          prev_ws;

  task automatic m_reset();
    pos    = -1;
    mw[0]  = '0;
    mw[1]  = '0;
    mrx[0] = '0;
    mrx[1] = '0;
    mdata  = '0;
    mlv    = 1'b0;
    mrv    = 1'b0;
  endtask

  function automatic logic m_sd();
    int k, ch;
    if (pos < 0) return 1'b0;
    k  = pos % SW;
    ch = pos / SW;
    if (k >= 1 && k <= DW) return mw[ch][DW-k];
    return 1'b0;
  endfunction

  task automatic m_step(input logic sdv);
    int k, ch;
    mlv = 1'b0;
    mrv = 1'b0;
    if (pos < 0) begin
      if (en) begin
        pos   = 0;
        mw[0] = tx_ldata;
        mw[1] = tx_rdata;
      end
    end else begin
      k  = pos % SW;
      ch = pos / SW;
      if (k >= 1 && k <= DW) mrx[ch][DW-k] = sdv;
      if (k == DW) begin
        mdata = mrx[ch];
        if (ch == 0) mlv = 1'b1;
        else         mrv = 1'b1;
      end
      pos++;
      if (pos == 2*SW) begin
        if (en) begin
          pos   = 0;
          mw[0] = tx_ldata;
          mw[1] = tx_rdata;
        end else begin
          pos = -1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic e_ws, e_busy, e_sd;
    e_ws   = (pos >= SW);
    e_busy = (pos >= 0);
    e_sd   = m_sd();
    vectors++;
    if (ws !== e_ws || busy !== e_busy || sd_out !== e_sd || data !== mdata ||
        l_vld !== mlv || r_vld !== mrv) begin
      miscompares++;
      $display("FAIL %s t=%0t pos=%0d ws/busy/sd_out/data/l_vld/r_vld got %b/%b/%b/%h/%b/%b want %b/%b/%b/%h/%b/%b",
               tag, $time, pos, ws, busy, sd_out, data, l_vld, r_vld,
               e_ws, e_busy, e_sd, mdata, mlv, mrv);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic sdv;
    sdv = loop_mode ? m_sd() : sd_drv;
    if (rst) m_reset();
    else     m_step(sdv);
    @(posedge sck);
    @(negedge sck);
    cyc++;
    check_all("cycle");
    if (l_vld === 1'b1) begin cap_l = data; n_l++; end
    if (r_vld === 1'b1) begin cap_r = data; n_r++; end
    if (ws === 1'b1 && prev_ws === 1'b0) begin
      if (last_rise >= 0) period = cyc - last_rise;
      last_rise = cyc;
    end
    prev_ws = ws;
  endtask

  task automatic run_to_idle(input string name);
    for (int c = 0; c < 3*SW && pos >= 0; c++) tick();
    chk(name, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [DW-1:0] tl;
    logic [DW-1:0] tr;
    logic [DW-1:0] el;
    logic [DW-1:0] er;
  } lb_vec_t;

  typedef struct {
    logic [SW-1:0] pat;
    logic [DW-1:0] exp;
  } pat_vec_t;

  lb_vec_t  lbt [4];
  pat_vec_t pt  [6];

  initial begin
    lbt[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    lbt[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    lbt[2] = '{8'h01, 8'h80, 8'h01, 8'h80};
    lbt[3] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};
    // pat bit k = sd_in level during left-slot cnt k
    pt[0]  = '{16'h1002, 8'h80};
    pt[1]  = '{16'h0001, 8'h00};
    pt[2]  = '{16'h0100, 8'h01};
    pt[3]  = '{16'h01FE, 8'hFF};
    pt[4]  = '{16'hFE00, 8'h00};
    pt[5]  = '{16'h0014, 8'h50};

    rst = 1'b1; en = 1'b0; sd_drv = 1'b0; loop_mode = 1'b0;
    tx_ldata = '0; tx_rdata = '0;
    n_l = 0; n_r = 0; cyc = 0; last_rise = -1; period = -1; prev_ws = 1'b0;
    cap_l = '0; cap_r = '0;
    m_reset();
    repeat (2) @(negedge sck);
    check_all("reset");
    rst = 1'b0;
    tick();
    tick();

    // Loopback table
    for (int i = 0; i < 4; i++) begin
      tx_ldata = lbt[i].tl; tx_rdata = lbt[i].tr; loop_mode = 1'b1;
      n_l = 0; n_r = 0; en = 1'b1;
      tick();
      en = 1'b0;
      run_to_idle("lb_idle");
      chk("lb_l_count", 32'(n_l), 32'd1);
      chk("lb_r_count", 32'(n_r), 32'd1);
      chk("lb_l_data", 32'(cap_l), 32'(lbt[i].el));
      chk("lb_r_data", 32'(cap_r), 32'(lbt[i].er));
    end

    // Bit-position / slot padding table
    loop_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sd_drv = 1'b0; n_l = 0; n_r = 0; en = 1'b1;
      tick();
      en = 1'b0;
      for (int c = 0; c < 3*SW && pos >= 0; c++) begin
        sd_drv = (pos < SW) ? pt[i].pat[pos] : 1'b0;
        tick();
      end
      sd_drv = 1'b0;
      chk("pat_l_count", 32'(n_l), 32'd1);
      chk("pat_l_data", 32'(cap_l), 32'(pt[i].exp));
      chk("pat_r_data", 32'(cap_r), 32'd0);
    end

    // Mid-frame tx change; back-to-back frames for ws period
    tx_ldata = 8'hA5; tx_rdata = 8'h3C; loop_mode = 1'b1;
    n_l = 0; n_r = 0; last_rise = -1; period = -1; en = 1'b1;
    tick();
    for (int c = 0; c < 8 && pos != 4; c++) tick();
    tx_ldata = 8'hFF;
    for (int c = 0; c < 2*SW && n_l < 1; c++) tick();
    chk("midchg_first", 32'(cap_l), 32'hA5);
    for (int c = 0; c < 3*SW && n_l < 2; c++) tick();
    chk("midchg_next", 32'(cap_l), 32'hFF);
    en = 1'b0;
    run_to_idle("midchg_idle");
    chk("ws_period", 32'(period), 32'(2*SW));

    // en dropped at left cnt=3
    tx_ldata = 8'h96; tx_rdata = 8'h3C;
    n_l = 0; n_r = 0; en = 1'b1;
    tick();
    for (int c = 0; c < 8 && pos != 3; c++) tick();
    en = 1'b0;
    run_to_idle("endrop_idle");
    chk("endrop_l_count", 32'(n_l), 32'd1);
    chk("endrop_r_count", 32'(n_r), 32'd1);
    chk("endrop_l_data", 32'(cap_l), 32'h96);
    chk("endrop_ws", 32'(ws), 32'd0);
    chk("endrop_sd_out", 32'(sd_out), 32'd0);

    // Reset mid-RIGHT at cnt=5
    en = 1'b1;
    tick();
    for (int c = 0; c < 2*SW && pos != SW+5; c++) tick();
    rst = 1'b1;
    m_reset();
    #1;
    chk("rst_ws", 32'(ws), 32'd0);
    chk("rst_sd_out", 32'(sd_out), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_l_vld", 32'(l_vld), 32'd0);
    chk("rst_r_vld", 32'(r_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge sck);
    n_l = 0; n_r = 0;
    en = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2*SW; c++) tick();
    chk("post_rst_l_count", 32'(n_l), 32'd0);
    chk("post_rst_r_count", 32'(n_r), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    tx_ldata = 8'hA5; tx_rdata = 8'h3C; en = 1'b1;
    tick();
    en = 1'b0;
    run_to_idle("restart_idle");
    chk("restart_l_data", 32'(cap_l), 32'hA5);
    chk("restart_r_data", 32'(cap_r), 32'h3C);

    // Randomized run against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 29) == 0) en = ~en;
      tx_ldata = DW'($urandom);
      tx_rdata = DW'($urandom);
      sd_drv   = 1'($urandom_range(0, 1));
      if (c % 97 == 0) loop_mode = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    en  = 1'b0;
    tick();
    run_to_idle("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
